// File: rtl/cnn_sched_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cnn_sched_pkg : scheduler state encoding, default widths, tile-extent helper
// rev 1.0
// -----------------------------------------------------------------------------
package cnn_sched_pkg;

   localparam int DIM_W_DEF = 8;
   localparam int K_W_DEF   = 4;
   localparam int EXT_W     = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      COMPUTE = 3'd2,
      STORE   = 3'd3,
      DONE    = 3'd4
   } sched_state_t;

   function automatic logic [EXT_W-1:0] min_ext(input logic [EXT_W-1:0] a,
                                                input logic [EXT_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   // Extent of a tile starting at base: the tile size, clipped at the map edge.
   function automatic logic [EXT_W-1:0] tile_extent(input logic [EXT_W-1:0] tsize,
                                                    input logic [EXT_W-1:0] dim,
                                                    input logic [EXT_W-1:0] base);
      return min_ext(tsize, dim - base);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_tile_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cnn_tile_counter : one tiling dimension - base register, clipped extent, wrap
// rev 1.0
// -----------------------------------------------------------------------------
module cnn_tile_counter
   import cnn_sched_pkg::*;
#(
   parameter int DIM_W = DIM_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             step,
   input  logic [DIM_W-1:0] dim,
   input  logic [DIM_W-1:0] tsize,
   output logic [DIM_W-1:0] base,
   output logic [DIM_W-1:0] extent,
   output logic             last
);

   logic [DIM_W-1:0] r_base;
   logic [DIM_W:0]   w_next_sum;

   // One extra bit so base+T near the top of the range cannot wrap silently.
   assign w_next_sum = {1'b0, r_base} + {1'b0, tsize};
   assign last       = (w_next_sum >= {1'b0, dim});
   assign base       = r_base;
   assign extent     = DIM_W'(tile_extent(EXT_W'(tsize), EXT_W'(dim), EXT_W'(r_base)));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_base <= '0;
      end else if (step) begin
         r_base <= last ? '0 : w_next_sum[DIM_W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/cnn_tile_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cnn_tile_scheduler : walks channel/row/column tiles, sequencing load, KxK
// compute and store per tile. Optional cycle counter: CNN_SCHED_PERF_EN. rev 1.0
// -----------------------------------------------------------------------------
module cnn_tile_scheduler
   import cnn_sched_pkg::*;
#(
   parameter int DIM_W = DIM_W_DEF,
   parameter int K_W   = K_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIM_W-1:0] cfg_rows,
   input  logic [DIM_W-1:0] cfg_cols,
   input  logic [DIM_W-1:0] cfg_chans,
   input  logic [DIM_W-1:0] cfg_tr,
   input  logic [DIM_W-1:0] cfg_tc,
   input  logic [DIM_W-1:0] cfg_tm,
   input  logic [K_W-1:0]   cfg_k,
   output logic             ld_req,
   input  logic             ld_ack,
   output logic             st_req,
   input  logic             st_ack,
   output logic [DIM_W-1:0] tile_row,
   output logic [DIM_W-1:0] tile_col,
   output logic [DIM_W-1:0] tile_ch,
   output logic [DIM_W-1:0] tile_nr,
   output logic [DIM_W-1:0] tile_nc,
   output logic [DIM_W-1:0] tile_nm,
   output logic             ce_en,
   output logic [K_W-1:0]   ce_ki,
   output logic [K_W-1:0]   ce_kj,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic [31:0]      perf_cycles
);

   sched_state_t     r_state;
   sched_state_t     w_state_nx;

   logic [DIM_W-1:0] r_rows;
   logic [DIM_W-1:0] r_cols;
   logic [DIM_W-1:0] r_chans;
   logic [DIM_W-1:0] r_tr;
   logic [DIM_W-1:0] r_tc;
   logic [DIM_W-1:0] r_tm;
   logic [K_W-1:0]   r_k;
   logic [K_W-1:0]   r_ki;
   logic [K_W-1:0]   r_kj;
   logic             r_cfg_err;

   logic             w_cfg_ok;
   logic             w_start_ok;
   logic [K_W-1:0]   w_k_max;
   logic             w_last_tap;
   logic             w_advance;
   logic             w_col_last;
   logic             w_row_last;
   logic             w_chan_last;
   logic             w_last_tile;

   assign w_cfg_ok   = (cfg_rows != '0) && (cfg_cols != '0) && (cfg_chans != '0) &&
                       (cfg_tr != '0) && (cfg_tc != '0) && (cfg_tm != '0) && (cfg_k != '0);
   assign w_start_ok = (r_state == IDLE) && start && w_cfg_ok;
   assign w_k_max    = r_k - K_W'(1);
   assign w_last_tap = (r_ki == w_k_max) && (r_kj == w_k_max);
   assign w_advance  = (r_state == STORE) && st_ack;
   assign w_last_tile = w_col_last && w_row_last && w_chan_last;

   // Layer configuration is captured once; later changes on the inputs are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rows  <= '0;
         r_cols  <= '0;
         r_chans <= '0;
         r_tr    <= '0;
         r_tc    <= '0;
         r_tm    <= '0;
         r_k     <= '0;
      end else if (w_start_ok) begin
         r_rows  <= cfg_rows;
         r_cols  <= cfg_cols;
         r_chans <= cfg_chans;
         r_tr    <= cfg_tr;
         r_tc    <= cfg_tc;
         r_tm    <= cfg_tm;
         r_k     <= cfg_k;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= (r_state == IDLE) && start && !w_cfg_ok;
      end
   end

   // Kernel tap walk: column index fastest; held at zero outside COMPUTE.
   always_ff @(posedge clk) begin
      if (rst || (r_state != COMPUTE)) begin
         r_ki <= '0;
         r_kj <= '0;
      end else if (r_kj == w_k_max) begin
         r_kj <= '0;
         r_ki <= (r_ki == w_k_max) ? '0 : r_ki + K_W'(1);
      end else begin
         r_kj <= r_kj + K_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      ld_req     = 1'b0;
      st_req     = 1'b0;
      ce_en      = 1'b0;
      done       = 1'b0;
      busy       = 1'b1;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (w_start_ok) begin
               w_state_nx = LOAD;
            end
         end
         LOAD: begin
            ld_req = 1'b1;
            if (ld_ack) begin
               w_state_nx = COMPUTE;
            end
         end
         COMPUTE: begin
            ce_en = 1'b1;
            if (w_last_tap) begin
               w_state_nx = STORE;
            end
         end
         STORE: begin
            st_req = 1'b1;
            if (st_ack) begin
               w_state_nx = w_last_tile ? DONE : LOAD;
            end
         end
         DONE: begin
            done       = 1'b1;
            w_state_nx = IDLE;
         end
         default: begin
            busy       = 1'b0;
            w_state_nx = IDLE;
         end
      endcase
   end

   // Column is the innermost loop; its wrap carries into row, then channel.
   cnn_tile_counter #(.DIM_W(DIM_W)) u_col_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (w_start_ok),
      .step   (w_advance),
      .dim    (r_cols),
      .tsize  (r_tc),
      .base   (tile_col),
      .extent (tile_nc),
      .last   (w_col_last)
   );

   cnn_tile_counter #(.DIM_W(DIM_W)) u_row_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (w_start_ok),
      .step   (w_advance && w_col_last),
      .dim    (r_rows),
      .tsize  (r_tr),
      .base   (tile_row),
      .extent (tile_nr),
      .last   (w_row_last)
   );

   cnn_tile_counter #(.DIM_W(DIM_W)) u_chan_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (w_start_ok),
      .step   (w_advance && w_col_last && w_row_last),
      .dim    (r_chans),
      .tsize  (r_tm),
      .base   (tile_ch),
      .extent (tile_nm),
      .last   (w_chan_last)
   );

   assign ce_ki   = r_ki;
   assign ce_kj   = r_kj;
   assign cfg_err = r_cfg_err;

`ifdef CNN_SCHED_PERF_EN
   logic [31:0] r_perf;

   always_ff @(posedge clk) begin
      if (rst || w_start_ok) begin
         r_perf <= '0;
      end else if (busy && (r_perf != 32'hFFFF_FFFF)) begin
         r_perf <= r_perf + 32'd1;
      end
   end

   assign perf_cycles = r_perf;
`else
   assign perf_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnn_tile_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_cnn_tile_scheduler : randomized layers checked against a tile-list model
// rev 1.0
// -----------------------------------------------------------------------------
module tb_cnn_tile_scheduler;

   logic       clk = 1'b0;
   logic       rst, start, ld_ack, st_ack;
   logic [7:0] cfg_rows, cfg_cols, cfg_chans, cfg_tr, cfg_tc, cfg_tm;
   logic [3:0] cfg_k;
   logic       ld_req, st_req, ce_en, busy, done, cfg_err;
   logic [7:0] tile_row, tile_col, tile_ch, tile_nr, tile_nc, tile_nm;
   logic [3:0] ce_ki, ce_kj;
   logic [31:0] perf_cycles;

   always #5 clk = ~clk;

   cnn_tile_scheduler #(.DIM_W(8), .K_W(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_chans(cfg_chans),
      .cfg_tr(cfg_tr), .cfg_tc(cfg_tc), .cfg_tm(cfg_tm), .cfg_k(cfg_k),
      .ld_req(ld_req), .ld_ack(ld_ack), .st_req(st_req), .st_ack(st_ack),
      .tile_row(tile_row), .tile_col(tile_col), .tile_ch(tile_ch),
      .tile_nr(tile_nr), .tile_nc(tile_nc), .tile_nm(tile_nm),
      .ce_en(ce_en), .ce_ki(ce_ki), .ce_kj(ce_kj),
      .busy(busy), .done(done), .cfg_err(cfg_err), .perf_cycles(perf_cycles)
   );

   int checks = 0;
   int failures = 0;

   typedef struct { int r; int c; int m; int nr; int nc; int nm; } tile_t;
   tile_t tiles[$];

   // Model: 0 idle, 1 waiting for load, 2 kernel walk, 3 waiting for store, 4 done
   int     m_phase = 0, m_tile = 0, m_tap = 0, m_k = 1, m_wait = 0, m_err = 0;
   longint m_perf = 0;
   int     ack_mode = 0;

   int obs_row[$], obs_col[$], obs_nr[$], obs_nc[$];
   int ce_cnt, ld_cnt, st_cnt, done_cyc, prev_ld;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic build_tiles();
      tile_t t;
      tiles.delete();
      for (int ch = 0; ch < int'(cfg_chans); ch += int'(cfg_tm))
         for (int r = 0; r < int'(cfg_rows); r += int'(cfg_tr))
            for (int c = 0; c < int'(cfg_cols); c += int'(cfg_tc)) begin
               t.r = r; t.c = c; t.m = ch;
               t.nr = imin(int'(cfg_tr), int'(cfg_rows) - r);
               t.nc = imin(int'(cfg_tc), int'(cfg_cols) - c);
               t.nm = imin(int'(cfg_tm), int'(cfg_chans) - ch);
               tiles.push_back(t);
            end
   endtask

   task automatic model_step();
      int prev;
      prev = m_phase;
      if (rst) begin
         m_phase = 0; m_err = 0; m_perf = 0; m_wait = 0;
         return;
      end
      if (m_phase != 0 && m_perf < 64'hFFFF_FFFF) m_perf++;
      m_err = 0;
      case (m_phase)
         0: if (start) begin
               if (cfg_rows == 0 || cfg_cols == 0 || cfg_chans == 0 || cfg_tr == 0 ||
                   cfg_tc == 0 || cfg_tm == 0 || cfg_k == 0) m_err = 1;
               else begin
                  build_tiles();
                  m_k = int'(cfg_k); m_tile = 0; m_phase = 1; m_perf = 0;
               end
            end
         1: if (ld_ack) begin m_phase = 2; m_tap = 0; end
         2: if (m_tap == m_k * m_k - 1) m_phase = 3; else m_tap++;
         3: if (st_ack) begin
               if (m_tile == tiles.size() - 1) m_phase = 4;
               else begin m_tile++; m_phase = 1; end
            end
         default: m_phase = 0;
      endcase
      m_wait = (m_phase == prev) ? m_wait + 1 : 0;
   endtask

   task automatic compare();
      chk("busy",    64'(busy),    64'(m_phase != 0));
      chk("ld_req",  64'(ld_req),  64'(m_phase == 1));
      chk("ce_en",   64'(ce_en),   64'(m_phase == 2));
      chk("st_req",  64'(st_req),  64'(m_phase == 3));
      chk("done",    64'(done),    64'(m_phase == 4));
      chk("cfg_err", 64'(cfg_err), 64'(m_err));
      chk("ce_ki",   64'(ce_ki),   64'((m_phase == 2) ? m_tap / m_k : 0));
      chk("ce_kj",   64'(ce_kj),   64'((m_phase == 2) ? m_tap % m_k : 0));
      if (m_phase >= 1 && m_phase <= 3) begin
         chk("tile_row", 64'(tile_row), 64'(tiles[m_tile].r));
         chk("tile_col", 64'(tile_col), 64'(tiles[m_tile].c));
         chk("tile_ch",  64'(tile_ch),  64'(tiles[m_tile].m));
         chk("tile_nr",  64'(tile_nr),  64'(tiles[m_tile].nr));
         chk("tile_nc",  64'(tile_nc),  64'(tiles[m_tile].nc));
         chk("tile_nm",  64'(tile_nm),  64'(tiles[m_tile].nm));
      end
`ifdef CNN_SCHED_PERF_EN
      chk("perf_cycles", 64'(perf_cycles), 64'(m_perf));
`else
      chk("perf_cycles", 64'(perf_cycles), 64'd0);
`endif
   endtask

   task automatic choose_acks();
      case (ack_mode)
         0: begin ld_ack = 1'b1; st_ack = 1'b1; end
         1: begin ld_ack = ($urandom_range(0, 2) == 0); st_ack = ($urandom_range(0, 2) == 0); end
         default: begin
            ld_ack = (m_phase == 1) && (m_wait >= 3);
            st_ack = (m_phase == 3) && (m_wait >= 2);
         end
      endcase
   endtask

   task automatic step();
      choose_acks();
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic set_cfg(input int r, input int c, input int m,
                          input int tr, input int tc, input int tm, input int k);
      cfg_rows = 8'(r); cfg_cols = 8'(c); cfg_chans = 8'(m);
      cfg_tr = 8'(tr); cfg_tc = 8'(tc); cfg_tm = 8'(tm); cfg_k = 4'(k);
   endtask

   task automatic record(input int cyc);
      if (ld_req && !prev_ld) begin
         obs_row.push_back(int'(tile_row)); obs_col.push_back(int'(tile_col));
         obs_nr.push_back(int'(tile_nr));   obs_nc.push_back(int'(tile_nc));
      end
      prev_ld = int'(ld_req);
      ce_cnt += int'(ce_en);
      ld_cnt += int'(ld_req);
      st_cnt += int'(st_req);
      if (done) done_cyc = cyc;
   endtask

   task automatic run_layer(input int r, input int c, input int m, input int tr, input int tc,
                            input int tm, input int k, input int amode, input bit noise);
      int cyc;
      obs_row.delete(); obs_col.delete(); obs_nr.delete(); obs_nc.delete();
      ce_cnt = 0; ld_cnt = 0; st_cnt = 0; done_cyc = -1; prev_ld = 0;
      ack_mode = amode;
      set_cfg(r, c, m, tr, tc, tm, k);
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 1;
      record(cyc);
      while (m_phase != 0 && cyc < 20000) begin
         if (noise) begin
            set_cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 15));
            start = ($urandom_range(0, 3) == 0);
         end
         step();
         cyc++;
         record(cyc);
      end
      start = 1'b0;
      if (m_phase != 0) begin
         checks++; failures++;
         $display("FAIL layer_timeout actual=busy expected=idle within 20000 cycles");
      end
   endtask

   initial begin
      int rr, cc, mm;
      rst = 1'b1; start = 1'b0; ld_ack = 1'b0; st_ack = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0);
      step(); step();
      rst = 1'b0;
      step();
      chk("reset_busy",   64'(busy),   64'd0);
      chk("reset_ld_req", 64'(ld_req), 64'd0);
      chk("reset_nr",     64'(tile_nr), 64'd0);
      chk("reset_perf",   64'(perf_cycles), 64'd0);

      // 2x2 tiles of a 4x4 map, 3x3 kernel, immediate acks
      run_layer(4, 4, 1, 2, 2, 1, 3, 0, 1'b0);
      chk("t1_done_cycle", 64'(done_cyc), 64'd45);
      chk("t1_ce_cycles",  64'(ce_cnt),   64'd36);
      chk("t1_tiles",      64'(obs_row.size()), 64'd4);
      if (obs_row.size() == 4) begin
         chk("t1_row1", 64'(obs_row[1]), 64'd0); chk("t1_col1", 64'(obs_col[1]), 64'd2);
         chk("t1_row2", 64'(obs_row[2]), 64'd2); chk("t1_col2", 64'(obs_col[2]), 64'd0);
         chk("t1_row3", 64'(obs_row[3]), 64'd2); chk("t1_col3", 64'(obs_col[3]), 64'd2);
      end
`ifdef CNN_SCHED_PERF_EN
      chk("t1_perf", 64'(perf_cycles), 64'd45);
`else
      chk("t1_perf", 64'(perf_cycles), 64'd0);
`endif

      // Clipped row extents
      run_layer(5, 3, 1, 2, 3, 1, 1, 0, 1'b0);
      chk("t2_tiles", 64'(obs_nr.size()), 64'd3);
      if (obs_nr.size() == 3) begin
         chk("t2_nr0", 64'(obs_nr[0]), 64'd2); chk("t2_nr1", 64'(obs_nr[1]), 64'd2);
         chk("t2_nr2", 64'(obs_nr[2]), 64'd1); chk("t2_nc2", 64'(obs_nc[2]), 64'd3);
      end

      // Delayed acks: load held 4 cycles, store 3 cycles, per tile
      run_layer(4, 4, 1, 2, 2, 1, 3, 2, 1'b0);
      chk("t3_ld_cycles", 64'(ld_cnt), 64'd16);
      chk("t3_st_cycles", 64'(st_cnt), 64'd12);
      chk("t3_ce_cycles", 64'(ce_cnt), 64'd36);

      // Zero tile size is rejected
      set_cfg(4, 4, 1, 2, 0, 1, 3);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("err_pulse", 64'(cfg_err), 64'd1);
      chk("err_busy",  64'(busy),    64'd0);
      step();
      chk("err_ld_req", 64'(ld_req),  64'd0);
      chk("err_clear",  64'(cfg_err), 64'd0);

      // Wide edges: base+T crosses 255
      run_layer(1, 250, 1, 1, 128, 1, 2, 1, 1'b0);
      chk("t5_tiles", 64'(obs_nc.size()), 64'd2);
      if (obs_nc.size() == 2) begin
         chk("t5_nc0", 64'(obs_nc[0]), 64'd128); chk("t5_nc1", 64'(obs_nc[1]), 64'd122);
      end
      run_layer(255, 1, 1, 200, 1, 1, 1, 0, 1'b0);
      if (obs_nr.size() == 2) chk("t6_nr1", 64'(obs_nr[1]), 64'd55);
      else chk("t6_tiles", 64'(obs_nr.size()), 64'd2);

      // Reset during the kernel walk
      ack_mode = 0;
      set_cfg(4, 4, 1, 2, 2, 1, 3);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 100 && !(m_phase == 2 && m_tap == 4); i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_busy",  64'(busy),     64'd0);
      chk("rst_ce_en", 64'(ce_en),    64'd0);
      chk("rst_ki",    64'(ce_ki),    64'd0);
      chk("rst_nr",    64'(tile_nr),  64'd0);
      chk("rst_done",  64'(done),     64'd0);
      run_layer(4, 4, 1, 2, 2, 1, 3, 0, 1'b0);
      chk("rst_rerun_done", 64'(done_cyc), 64'd45);

      // Randomized layers, random acks, config and start noise while busy
      for (int n = 0; n < 8; n++) begin
         rr = $urandom_range(1, 5); cc = $urandom_range(1, 5); mm = $urandom_range(1, 4);
         run_layer(rr, cc, mm, $urandom_range(1, 6), $urandom_range(1, 6),
                   $urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(0, 1), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
